// File: rtl/ss_xfer_engine.sv
// rtl/ss_xfer_engine.sv - save-state transfer engine between the mapper save-state port and a state buffer
// Save sweeps mapper state into the buffer; restore checks the mapper ID, then replays bytes on synthesized M2.
module ss_xfer_engine #(
    parameter int SS_LEN  = 128,
    parameter int ID_ADDR = 127,
    parameter int M2_HALF = 4,
    parameter int RD_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_save,
    input  logic       cmd_restore,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_dout,
    output logic       ss_m2,
    input  logic [7:0] ss_rdat,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdat,
    input  logic [7:0] mem_rdat,
    input  logic       mem_ack
);
    localparam logic [7:0] ID8       = 8'(ID_ADDR);
    localparam logic [7:0] RD_LAST   = 8'(RD_WAIT);
    localparam logic [7:0] M2_LAST   = 8'(M2_HALF - 1);
    localparam logic [7:0] SAVE_LAST = 8'(SS_LEN - 1);
    localparam logic [7:0] RST_LAST  = (ID_ADDR == SS_LEN - 1) ? 8'(SS_LEN - 2) : 8'(SS_LEN - 1);
    localparam logic [7:0] RST_FIRST = (ID_ADDR == 0) ? 8'd1 : 8'd0;

    typedef enum logic [3:0] {
        S_IDLE, S_SAVE_RD, S_SAVE_WR, S_CHK_RD, S_CHK_CMP, S_RST_RD, S_RST_SET,
        S_RST_HI, S_RST_LO, S_FIN_WE, S_FIN_ACT, S_DONE, S_ERR
    } state_t;

    state_t     state_q;
    logic [7:0] addr_q, cnt_q, id_q, addr_nxt_d;
    logic       done_q, err_q, act_q, we_q, m2_q, req_q, mwe_q;
    logic [7:0] ss_addr_q, dout_q, maddr_q, wdat_q;

    // Restore never touches the read-only ID byte, so stepping skips it.
    always_comb begin
        addr_nxt_d = addr_q + 8'd1;
        if (addr_nxt_d == ID8) addr_nxt_d = addr_q + 8'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 8'd0;
            cnt_q     <= 8'd0;
            id_q      <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            act_q     <= 1'b0;
            we_q      <= 1'b0;
            m2_q      <= 1'b0;
            req_q     <= 1'b0;
            mwe_q     <= 1'b0;
            ss_addr_q <= 8'd0;
            dout_q    <= 8'd0;
            maddr_q   <= 8'd0;
            wdat_q    <= 8'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_save && cmd_restore) begin
                        err_q <= 1'b1;
                    end else if (cmd_save) begin
                        err_q     <= 1'b0;
                        act_q     <= 1'b1;
                        addr_q    <= 8'd0;
                        ss_addr_q <= 8'd0;
                        cnt_q     <= 8'd0;
                        state_q   <= S_SAVE_RD;
                    end else if (cmd_restore) begin
                        err_q     <= 1'b0;
                        act_q     <= 1'b1;
                        ss_addr_q <= ID8;
                        maddr_q   <= ID8;
                        mwe_q     <= 1'b0;
                        req_q     <= 1'b1;
                        state_q   <= S_CHK_RD;
                    end
                end
                S_SAVE_RD: begin
                    if (cnt_q == RD_LAST) begin
                        wdat_q  <= ss_rdat;
                        maddr_q <= addr_q;
                        mwe_q   <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= S_SAVE_WR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_SAVE_WR: begin
                    if (mem_ack) begin
                        req_q <= 1'b0;
                        mwe_q <= 1'b0;
                        if (addr_q == SAVE_LAST) begin
                            state_q <= S_FIN_WE;
                        end else begin
                            addr_q    <= addr_q + 8'd1;
                            ss_addr_q <= addr_q + 8'd1;
                            cnt_q     <= 8'd0;
                            state_q   <= S_SAVE_RD;
                        end
                    end
                end
                S_CHK_RD: begin
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        id_q    <= mem_rdat;
                        cnt_q   <= 8'd0;
                        state_q <= S_CHK_CMP;
                    end
                end
                S_CHK_CMP: begin
                    if (cnt_q == RD_LAST) begin
                        if (ss_rdat != id_q) begin
                            state_q <= S_ERR;
                        end else begin
                            addr_q  <= RST_FIRST;
                            maddr_q <= RST_FIRST;
                            req_q   <= 1'b1;
                            state_q <= S_RST_RD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RST_RD: begin
                    if (mem_ack) begin
                        req_q     <= 1'b0;
                        dout_q    <= mem_rdat;
                        ss_addr_q <= addr_q;
                        we_q      <= 1'b1;
                        state_q   <= S_RST_SET;
                    end
                end
                // One setup cycle with address/data/we stable before M2 rises.
                S_RST_SET: begin
                    m2_q    <= 1'b1;
                    cnt_q   <= 8'd0;
                    state_q <= S_RST_HI;
                end
                S_RST_HI: begin
                    if (cnt_q == M2_LAST) begin
                        m2_q    <= 1'b0;
                        cnt_q   <= 8'd0;
                        state_q <= S_RST_LO;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RST_LO: begin
                    if (cnt_q == M2_LAST) begin
                        if (addr_q == RST_LAST) begin
                            state_q <= S_FIN_WE;
                        end else begin
                            addr_q  <= addr_nxt_d;
                            maddr_q <= addr_nxt_d;
                            req_q   <= 1'b1;
                            state_q <= S_RST_RD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_FIN_WE: begin
                    we_q    <= 1'b0;
                    state_q <= S_FIN_ACT;
                end
                S_FIN_ACT: begin
                    act_q   <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    act_q   <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign ss_act   = act_q;
    assign ss_we    = we_q;
    assign ss_addr  = ss_addr_q;
    assign ss_dout  = dout_q;
    assign ss_m2    = m2_q;
    assign mem_req  = req_q;
    assign mem_we   = mwe_q;
    assign mem_addr = maddr_q;
    assign mem_wdat = wdat_q;
endmodule

// File: tb/tb_ss_xfer_engine.sv
// tb/tb_ss_xfer_engine.sv - bench for ss_xfer_engine with mapper and buffer models
module tb_ss_xfer_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_save = 1'b0, cmd_restore = 1'b0;
    logic       busy, done, err, ss_act, ss_we, ss_m2, mem_req, mem_we, mem_ack;
    logic [7:0] ss_addr, ss_dout, ss_rdat, mem_addr, mem_wdat, mem_rdat;
    logic [7:0] id_map = 8'h25;

    always #5 clk = ~clk;

    ss_xfer_engine dut (
        .clk(clk), .rst(rst), .cmd_save(cmd_save), .cmd_restore(cmd_restore),
        .busy(busy), .done(done), .err(err), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_dout(ss_dout), .ss_m2(ss_m2), .ss_rdat(ss_rdat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .mem_rdat(mem_rdat), .mem_ack(mem_ack)
    );

    // Mapper readback: ID byte at 127, everything else addr ^ 5A.
    assign ss_rdat = (ss_addr == 8'd127) ? id_map : (ss_addr ^ 8'h5A);

    int         lat = 3;
    int         lat_cnt = 0;
    int         memwr_cnt = 0, memwr_bad = 0;
    logic [7:0] wr_prev = 8'hFF;
    logic [7:0] sav_mem [256];
    logic [7:0] rbuf [256];

    always @(posedge clk) begin
        #1;
        if (rst || mem_ack || !mem_req) begin
            mem_ack = 1'b0;
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (lat_cnt >= lat) begin
                mem_ack  = 1'b1;
                lat_cnt  = 0;
                mem_rdat = rbuf[mem_addr];
                if (mem_we) begin
                    if (mem_addr != 8'd0 && mem_addr != wr_prev + 8'd1) memwr_bad++;
                    wr_prev = mem_addr;
                    sav_mem[mem_addr] = mem_wdat;
                    memwr_cnt++;
                end
            end
        end
    end

    int         done_cnt = 0, we_cyc = 0, fall_cnt = 0, fall_bad = 0;
    logic       m2_prev = 1'b0;
    logic [7:0] fall_prev = 8'hFF;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ss_we) we_cyc++;
        if (m2_prev && !ss_m2 && ss_act && ss_we) begin
            fall_cnt++;
            if (ss_dout != ~ss_addr || ss_addr == 8'd127 ||
                (ss_addr != 8'd0 && ss_addr != fall_prev + 8'd1)) fall_bad++;
            fall_prev = ss_addr;
        end
        m2_prev = ss_m2;
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input bit s, input bit r);
        @(negedge clk);
        cmd_save = s;
        cmd_restore = r;
        @(negedge clk);
        cmd_save = 1'b0;
        cmd_restore = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_rbuf(input logic [7:0] id_byte);
        for (int k = 0; k < 127; k++) rbuf[k] = ~8'(k);
        rbuf[127] = id_byte;
    endtask

    function automatic logic [39:0] outs();
        return {busy, done, err, ss_act, ss_we, ss_m2, mem_req, mem_we,
                ss_addr, ss_dout, mem_addr, mem_wdat};
    endfunction

    typedef struct {
        bit         is_save;
        int         lat;
        logic [7:0] id_buf;
        logic [7:0] id_map;
        int         exp_done;
        logic       exp_err;
        int         exp_memwr;
        int         exp_falls;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int d0, w0, wb0, f0, fb0, we0, sbad;

        vecs[0] = '{1'b1, 3, 8'h00, 8'h25, 1, 1'b0, 128, 0};
        vecs[1] = '{1'b0, 3, 8'h04, 8'h04, 1, 1'b0, 0, 127};
        vecs[2] = '{1'b0, 3, 8'h05, 8'h04, 0, 1'b1, 0, 0};
        vecs[3] = '{1'b1, 1, 8'h00, 8'h25, 1, 1'b0, 128, 0};
        vecs[4] = '{1'b0, 1, 8'h04, 8'h04, 1, 1'b0, 0, 127};
        for (int k = 0; k < 256; k++) sav_mem[k] = 8'hEE;
        fill_rbuf(8'h04);

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs()), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            lat = vecs[i].lat;
            id_map = vecs[i].id_map;
            fill_rbuf(vecs[i].id_buf);
            d0 = done_cnt; w0 = memwr_cnt; wb0 = memwr_bad;
            f0 = fall_cnt; fb0 = fall_bad; we0 = we_cyc;
            pulse(vecs[i].is_save, !vecs[i].is_save);
            wait_idle($sformatf("v%0d", i));
            check($sformatf("v%0d_done", i), 64'(done_cnt - d0), 64'(vecs[i].exp_done));
            check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_memwr", i), 64'(memwr_cnt - w0), 64'(vecs[i].exp_memwr));
            check($sformatf("v%0d_memwr_order", i), 64'(memwr_bad - wb0), 64'd0);
            check($sformatf("v%0d_falls", i), 64'(fall_cnt - f0), 64'(vecs[i].exp_falls));
            check($sformatf("v%0d_fall_data", i), 64'(fall_bad - fb0), 64'd0);
            check($sformatf("v%0d_act_low", i), 64'(ss_act), 64'd0);
            if (vecs[i].is_save) begin
                sbad = 0;
                for (int k = 0; k < 128; k++)
                    if (sav_mem[k] !== (8'(k) ^ 8'h5A)) sbad++;
                check($sformatf("v%0d_buf_content", i), 64'(sbad), 64'd0);
                check($sformatf("v%0d_no_we", i), 64'(we_cyc - we0), 64'd0);
            end else if (vecs[i].exp_falls > 0) begin
                check($sformatf("v%0d_last_addr", i), 64'(fall_prev), 64'd126);
            end else begin
                check($sformatf("v%0d_no_we", i), 64'(we_cyc - we0), 64'd0);
            end
        end

        // Both commands together: rejected with err, then a lone save clears it.
        id_map = 8'h25;
        lat = 2;
        pulse(1'b1, 1'b1);
        check("both_err", 64'(err), 64'd1);
        check("both_idle", 64'({busy, ss_act, mem_req}), 64'd0);
        w0 = memwr_cnt; d0 = done_cnt;
        pulse(1'b1, 1'b0);
        check("save_after_both_busy", 64'(busy), 64'd1);
        check("save_after_both_err_clr", 64'(err), 64'd0);

        // A restore pulse mid-save is ignored.
        repeat (50) @(negedge clk);
        f0 = fall_cnt;
        pulse(1'b0, 1'b1);
        check("mid_save_busy", 64'(busy), 64'd1);
        wait_idle("mid_save");
        check("mid_save_memwr", 64'(memwr_cnt - w0), 64'd128);
        check("mid_save_done", 64'(done_cnt - d0), 64'd1);
        check("mid_save_falls", 64'(fall_cnt - f0), 64'd0);
        check("mid_save_err", 64'(err), 64'd0);

        // Reset during byte 40 of a restore with ss_m2 high.
        lat = 3;
        id_map = 8'h04;
        fill_rbuf(8'h04);
        f0 = fall_cnt;
        pulse(1'b0, 1'b1);
        begin
            int n = 0;
            while (!(ss_m2 && ss_addr == 8'd40) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("rst_reach_byte40", 64'({ss_m2, ss_addr}), 64'({1'b1, 8'd40}));
        end
        #2 rst = 1'b1;
        #1 check("rst_outputs", 64'(outs()), 64'd0);
        check("rst_falls_before", 64'(fall_cnt - f0), 64'd40);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_still_zero", 64'(outs()), 64'd0);
        id_map = 8'h25;
        w0 = memwr_cnt; wb0 = memwr_bad; d0 = done_cnt;
        pulse(1'b1, 1'b0);
        wait_idle("post_rst_save");
        check("post_rst_memwr", 64'(memwr_cnt - w0), 64'd128);
        check("post_rst_order", 64'(memwr_bad - wb0), 64'd0);
        check("post_rst_done", 64'(done_cnt - d0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
